// File: rtl/dds_sweep_controller.sv
// Frequency control word manager for a DDS: button strobes, UART commands and
// an automatic triangle sweep between KW_MIN and KW_MAX.
module dds_sweep_controller #(
    parameter logic [11:0] KW_MIN  = 12'd1,
    parameter logic [11:0] KW_MAX  = 12'd10,
    parameter logic [11:0] KW_INIT = 12'd5,
    parameter logic [23:0] DWELL   = 24'd12_500_000
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        Add_Pulse,
    input  logic        Sub_Pulse,
    input  logic        Mode_Pulse,
    input  logic [7:0]  Rx_Data,
    input  logic        Rx_Done,
    output logic [11:0] KW_Out,
    output logic        KW_Update,
    output logic        Sweep_Active,
    output logic        Cmd_Error
);

    localparam logic [1:0] ST_MANUAL     = 2'd0;
    localparam logic [1:0] ST_SWEEP_UP   = 2'd1;
    localparam logic [1:0] ST_SWEEP_DOWN = 2'd2;

    localparam logic CMD_IDLE = 1'b0;
    localparam logic CMD_ARG  = 1'b1;

    logic [11:0] kw_q, kw_d;
    logic [1:0]  mode_q, mode_d;
    logic        cmd_q, cmd_d;
    logic [23:0] dwell_q, dwell_d;
    logic        update_q, error_q, error_d, sweep_q;
    logic        sweeping, dwell_done, sweep_entry;
    logic [11:0] rx_word;

    function automatic logic [11:0] wrap_up(input logic [11:0] kw);
        return (kw == KW_MAX) ? KW_MIN : kw + 12'd1;
    endfunction

    function automatic logic [11:0] wrap_down(input logic [11:0] kw);
        return (kw == KW_MIN) ? KW_MAX : kw - 12'd1;
    endfunction

    assign rx_word    = {4'd0, Rx_Data};
    assign sweeping   = (mode_q != ST_MANUAL);
    assign dwell_done = sweeping && (dwell_q == DWELL - 24'd1);

    // Single priority chain: only the highest-priority event is serviced.
    always_comb begin
        kw_d        = kw_q;
        mode_d      = mode_q;
        cmd_d       = cmd_q;
        error_d     = 1'b0;
        sweep_entry = 1'b0;

        if (Rx_Done) begin
            if (cmd_q == CMD_ARG) begin
                cmd_d = CMD_IDLE;
                if (rx_word >= KW_MIN && rx_word <= KW_MAX) begin
                    kw_d   = rx_word;
                    mode_d = ST_MANUAL;
                end else begin
                    error_d = 1'b1;
                end
            end else begin
                case (Rx_Data)
                    8'h2B: begin
                        kw_d   = wrap_up(kw_q);
                        mode_d = ST_MANUAL;
                    end
                    8'h2D: begin
                        kw_d   = wrap_down(kw_q);
                        mode_d = ST_MANUAL;
                    end
                    8'h53: begin
                        mode_d      = ST_SWEEP_UP;
                        sweep_entry = 1'b1;
                    end
                    8'h4D:   mode_d  = ST_MANUAL;
                    8'h4C:   cmd_d   = CMD_ARG;
                    default: error_d = 1'b1;
                endcase
            end
        end else if (Mode_Pulse) begin
            if (mode_q == ST_MANUAL) begin
                mode_d      = ST_SWEEP_UP;
                sweep_entry = 1'b1;
            end else begin
                mode_d = ST_MANUAL;
            end
        end else if (Add_Pulse && !sweeping) begin
            kw_d = wrap_up(kw_q);
        end else if (Sub_Pulse && !sweeping) begin
            kw_d = wrap_down(kw_q);
        end else if (dwell_done) begin
            // Sweep bounces at the limits instead of wrapping.
            if (mode_q == ST_SWEEP_UP) begin
                if (kw_q < KW_MAX) begin
                    kw_d = kw_q + 12'd1;
                end else begin
                    kw_d   = kw_q - 12'd1;
                    mode_d = ST_SWEEP_DOWN;
                end
            end else begin
                if (kw_q > KW_MIN) begin
                    kw_d = kw_q - 12'd1;
                end else begin
                    kw_d   = kw_q + 12'd1;
                    mode_d = ST_SWEEP_UP;
                end
            end
        end

        if (mode_d == ST_MANUAL || sweep_entry || kw_d != kw_q || dwell_done) begin
            dwell_d = 24'd0;
        end else begin
            dwell_d = dwell_q + 24'd1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            kw_q     <= KW_INIT;
            mode_q   <= ST_MANUAL;
            cmd_q    <= CMD_IDLE;
            dwell_q  <= 24'd0;
            update_q <= 1'b0;
            error_q  <= 1'b0;
            sweep_q  <= 1'b0;
        end else begin
            kw_q     <= kw_d;
            mode_q   <= mode_d;
            cmd_q    <= cmd_d;
            dwell_q  <= dwell_d;
            update_q <= (kw_d != kw_q);
            error_q  <= error_d;
            sweep_q  <= (mode_d != ST_MANUAL);
        end
    end

    assign KW_Out       = kw_q;
    assign KW_Update    = update_q;
    assign Sweep_Active = sweep_q;
    assign Cmd_Error    = error_q;

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Directed bench for dds_sweep_controller with a short dwell so sweeps finish quickly.
module tb_dds_sweep_controller;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        Add_Pulse = 1'b0;
    logic        Sub_Pulse = 1'b0;
    logic        Mode_Pulse = 1'b0;
    logic [7:0]  Rx_Data = 8'h00;
    logic        Rx_Done = 1'b0;
    logic [11:0] KW_Out;
    logic        KW_Update;
    logic        Sweep_Active;
    logic        Cmd_Error;

    int total = 0;
    int bad   = 0;

    dds_sweep_controller #(
        .KW_MIN (12'd1),
        .KW_MAX (12'd10),
        .KW_INIT(12'd5),
        .DWELL  (24'd4)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .Add_Pulse   (Add_Pulse),
        .Sub_Pulse   (Sub_Pulse),
        .Mode_Pulse  (Mode_Pulse),
        .Rx_Data     (Rx_Data),
        .Rx_Done     (Rx_Done),
        .KW_Out      (KW_Out),
        .KW_Update   (KW_Update),
        .Sweep_Active(Sweep_Active),
        .Cmd_Error   (Cmd_Error)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hold the given inputs for one rising edge; returns at the following negedge.
    task automatic strobe(input logic add, input logic sub, input logic mode,
                          input logic rxd, input logic [7:0] data);
        @(negedge CLK);
        Add_Pulse  = add;
        Sub_Pulse  = sub;
        Mode_Pulse = mode;
        Rx_Done    = rxd;
        Rx_Data    = data;
        @(negedge CLK);
        Add_Pulse  = 1'b0;
        Sub_Pulse  = 1'b0;
        Mode_Pulse = 1'b0;
        Rx_Done    = 1'b0;
        Rx_Data    = 8'h00;
    endtask

    task automatic send_rx(input logic [7:0] data);
        strobe(1'b0, 1'b0, 1'b0, 1'b1, data);
    endtask

    initial begin
        logic [11:0] exp_kw;
        logic [11:0] sweep_seq [11];

        #12;
        check("rst_kw", KW_Out, 5);
        check("rst_upd", KW_Update, 0);
        check("rst_sweep", Sweep_Active, 0);
        check("rst_err", Cmd_Error, 0);
        @(negedge CLK);
        RSTn = 1'b1;

        exp_kw = 12'd5;
        for (int i = 0; i < 3; i++) begin
            strobe(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            exp_kw = exp_kw + 12'd1;
            check("add_kw", KW_Out, exp_kw);
            check("add_upd", KW_Update, 1);
        end
        for (int i = 0; i < 9; i++) begin
            strobe(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            exp_kw = (exp_kw == 12'd1) ? 12'd10 : exp_kw - 12'd1;
            check("sub_kw", KW_Out, exp_kw);
        end
        check("sub_final", KW_Out, 9);
        @(negedge CLK);
        check("upd_drop", KW_Update, 0);

        send_rx(8'h4C);
        check("l_noerr", Cmd_Error, 0);
        check("l_kw_hold", KW_Out, 9);
        send_rx(8'h0A);
        check("load_kw", KW_Out, 10);
        check("load_upd", KW_Update, 1);
        @(negedge CLK);
        check("load_upd_one", KW_Update, 0);
        send_rx(8'h4C);
        send_rx(8'h0B);
        check("load_oor_err", Cmd_Error, 1);
        check("load_oor_kw", KW_Out, 10);
        check("load_oor_upd", KW_Update, 0);
        @(negedge CLK);
        check("err_one", Cmd_Error, 0);
        send_rx(8'h4C);
        send_rx(8'h0A);
        check("load_same_upd", KW_Update, 0);
        check("load_same_kw", KW_Out, 10);

        strobe(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("pre_sweep_kw", KW_Out, 9);
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("sweep_on", Sweep_Active, 1);
        check("sweep_kw0", KW_Out, 9);
        sweep_seq = '{12'd10, 12'd9, 12'd8, 12'd7, 12'd6, 12'd5,
                      12'd4, 12'd3, 12'd2, 12'd1, 12'd2};
        for (int s = 0; s < 11; s++) begin
            repeat (3) @(negedge CLK);
            check("sweep_hold", KW_Out, (s == 0) ? 12'd9 : sweep_seq[s-1]);
            @(negedge CLK);
            check("sweep_step", KW_Out, sweep_seq[s]);
            check("sweep_upd", KW_Update, 1);
        end
        strobe(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("sweep_add_ignored", KW_Out, 2);
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("sweep_off", Sweep_Active, 0);

        send_rx(8'h4C);
        send_rx(8'h05);
        check("load5", KW_Out, 5);
        strobe(1'b1, 1'b0, 1'b0, 1'b1, 8'h2B);
        check("prio_kw", KW_Out, 6);
        @(negedge CLK);
        check("prio_kw_hold", KW_Out, 6);
        check("prio_manual", Sweep_Active, 0);

        send_rx(8'h41);
        check("bad_cmd_err", Cmd_Error, 1);
        check("bad_cmd_kw", KW_Out, 6);
        @(negedge CLK);
        check("bad_cmd_one", Cmd_Error, 0);

        send_rx(8'h4C);
        #2 RSTn = 1'b0;
        #1;
        check("midarg_rst_kw", KW_Out, 5);
        check("midarg_rst_err", Cmd_Error, 0);
        @(negedge CLK);
        RSTn = 1'b1;
        send_rx(8'h07);
        check("after_rst_err", Cmd_Error, 1);
        check("after_rst_kw", KW_Out, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dds_sweep_controller.md
DDS_SWEEP_CONTROLLER -- requirements
Module: dds_sweep_controller

Interface
REQ-001 Parameter KW_MIN, default 12'd1, lowest legal frequency control word.
REQ-002 Parameter KW_MAX, default 12'd10, highest legal frequency control word.
REQ-003 Parameter KW_INIT, default 12'd5, control word loaded at reset.
REQ-004 Parameter DWELL, default 24'd12_500_000, clock cycles per sweep step (250 ms at 50 MHz).
REQ-005 CLK  input  1  system clock, all logic on rising edge.
REQ-006 RSTn  input  1  asynchronous active-low reset.
REQ-007 Add_Pulse  input  1  debounced one-cycle button strobe, step KW up.
REQ-008 Sub_Pulse  input  1  debounced one-cycle button strobe, step KW down.
REQ-009 Mode_Pulse  input  1  debounced one-cycle strobe, toggle manual/sweep.
REQ-010 Rx_Data  input  8  UART receiver byte, valid when Rx_Done=1.
REQ-011 Rx_Done  input  1  one-cycle UART byte-valid strobe.
REQ-012 KW_Out  output  12  frequency control word to DDS phase accumulator.
REQ-013 KW_Update  output  1  one-cycle strobe, high in the cycle KW_Out takes a new value.
REQ-014 Sweep_Active  output  1  high while in SWEEP_UP or SWEEP_DOWN.
REQ-015 Cmd_Error  output  1  one-cycle strobe on unknown command byte or out-of-range load value.

Function
REQ-016 Mode FSM states: MANUAL, SWEEP_UP, SWEEP_DOWN; command FSM states: CMD_IDLE, CMD_ARG.
REQ-017 All outputs registered; KW_Out changes exactly one cycle after the accepted strobe.
REQ-018 Step up: KW==KW_MAX -> KW_MIN (wrap), else KW+1; step down: KW==KW_MIN -> KW_MAX (wrap), else KW-1.
REQ-019 UART bytes in CMD_IDLE: 0x2B '+' step up; 0x2D '-' step down; 0x53 'S' enter SWEEP_UP; 0x4D 'M' enter MANUAL; 0x4C 'L' go to CMD_ARG; any other byte pulses Cmd_Error, no state change.
REQ-020 CMD_ARG: next Rx_Done byte b; KW_MIN<=b<=KW_MAX -> KW={4'd0,b}, mode MANUAL; else Cmd_Error, KW unchanged; return to CMD_IDLE in both cases.
REQ-021 '+' and '-' accepted in any mode and force MANUAL; 'L' accepted in any mode.
REQ-022 Add_Pulse/Sub_Pulse act only in MANUAL; ignored in sweep states.
REQ-023 Mode_Pulse: MANUAL -> SWEEP_UP; SWEEP_UP/SWEEP_DOWN -> MANUAL.
REQ-024 Priority in one cycle: Rx_Done > Mode_Pulse > Add_Pulse > Sub_Pulse > dwell step; only the highest is serviced, others dropped.
REQ-025 Dwell counter 24 bits, cleared on every sweep entry and every KW change; counts while sweeping; at DWELL-1 the sweep step occurs and counter returns to 0.
REQ-026 SWEEP_UP step: KW<KW_MAX -> KW+1; KW>=KW_MAX -> KW-1, state SWEEP_DOWN (no wrap).
REQ-027 SWEEP_DOWN step: KW>KW_MIN -> KW-1; KW<=KW_MIN -> KW+1, state SWEEP_UP.
REQ-028 KW_Update pulses only when KW_Out value actually changes; a load equal to current KW gives no pulse.
REQ-029 Dwell counter held at 0 in MANUAL.

Reset
REQ-030 RSTn low asynchronously forces KW_Out=KW_INIT, mode MANUAL, CMD_IDLE, dwell counter 0, KW_Update=0, Sweep_Active=0, Cmd_Error=0.
REQ-031 Reset mid-CMD_ARG or mid-sweep discards pending argument and dwell progress; first byte after release is parsed as a command.

Verification
REQ-032 Reset release, 3 Add_Pulse -> KW_Out 5,6,7,8; then 9 Sub_Pulse -> ends at 9 via wrap 1->10.
REQ-033 Rx 0x4C then 0x0A -> KW_Out=10, one KW_Update; Rx 0x4C then 0x0B -> Cmd_Error pulse, KW_Out stays 10.
REQ-034 DWELL=4, KW=9, Mode_Pulse -> Sweep_Active=1, KW 10 after 4 cycles, then 9 (SWEEP_DOWN), ... 1, then 2 (SWEEP_UP).
REQ-035 Same cycle Rx_Done(0x2B) and Add_Pulse at KW=5 -> KW_Out=6 only, mode MANUAL.
REQ-036 Rx 0x41 -> Cmd_Error one cycle, KW_Out unchanged; RSTn pulse low during CMD_ARG then Rx 0x07 -> Cmd_Error, KW_Out=5.
